// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the slide-switch conditioner: FSM encoding, switch
// width shared with AluTop, and counter sizing.
package sw_debounce_pkg;

  localparam int SW_WIDTH         = 10;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Counter only has to reach n-1; keep at least one bit for n == 1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_sync2.sv
// Two-flop synchroniser for an asynchronous bus; both stages clear to zero
// on synchronous active-low reset.
module sw_debounce_sync2
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/sw_debounce.sv
// Whole-vector switch debouncer: synchronises the raw pins, times a candidate
// value, and publishes it with a one-cycle change pulse once it has held.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_sw_raw,
  output logic [WIDTH-1:0] io_sw,
  output logic             io_changed,
  output logic             io_busy
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sw_sync;

  state_e           state_d,   state_q;
  logic [WIDTH-1:0] stable_d,  stable_q;
  logic [WIDTH-1:0] cand_d,    cand_q;
  logic [CNT_W-1:0] cnt_d,     cnt_q;
  logic             changed_d, changed_q;

  sw_debounce_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (io_sw_raw),
    .q     (sw_sync)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      stable_q  <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sw_sync != stable_q) begin
          cand_d  = sw_sync;
          cnt_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sw_sync == stable_q) begin
          // Bounced back to the published value: drop the candidate quietly.
          state_d = ST_IDLE;
        end else if (sw_sync != cand_q) begin
          cand_d = sw_sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = cand_q;
          changed_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    io_busy    = (state_q == ST_COUNT);
    io_sw      = stable_q;
    io_changed = changed_q;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4: a vector table of
// per-cycle inputs and expected outputs, then bounce and latency sequences.
module tb_sw_debounce;

  localparam int W = 10;
  localparam int DC = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] io_sw_raw;
  logic [W-1:0] io_sw;
  logic         io_changed;
  logic         io_busy;

  int errors;
  int checks;

  typedef struct {
    logic [W-1:0] raw;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         chg;
    logic         busy;
    string        tag;
  } vec_t;

  vec_t vecs[$];

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io_sw_raw  (io_sw_raw),
    .io_sw      (io_sw),
    .io_changed (io_changed),
    .io_busy    (io_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [W-1:0] raw, input logic rst_n,
                              input logic [W-1:0] sw, input logic chg,
                              input logic busy, input string tag);
    vec_t v;
    v.raw = raw; v.rst_n = rst_n; v.sw = sw; v.chg = chg; v.busy = busy;
    v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] raw, input logic rst_n);
    @(negedge clk);
    io_sw_raw = raw;
    reset     = rst_n;
    @(posedge clk);
    #1;
  endtask

  // Four rows of the candidate being timed, then the publish and hold rows.
  function automatic void add_change(input logic [W-1:0] from_v,
                                     input logic [W-1:0] to_v,
                                     input string tag);
    add(to_v, 1'b1, from_v, 1'b0, 1'b0, {tag, "_sync"});
    add(to_v, 1'b1, from_v, 1'b0, 1'b0, {tag, "_sync"});
    for (int i = 0; i < DC; i++) add(to_v, 1'b1, from_v, 1'b0, 1'b1, {tag, "_busy"});
    add(to_v, 1'b1, to_v, 1'b1, 1'b0, {tag, "_upd"});
    add(to_v, 1'b1, to_v, 1'b0, 1'b0, {tag, "_hold"});
  endfunction

  initial begin
    int pulses;
    int lat;
    bit found;
    logic [W-1:0] sw_seen;
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    io_sw_raw = '0;

    // Reset held with all switches up
    for (int i = 0; i < 3; i++) add(10'h3FF, 1'b0, 10'h000, 1'b0, 1'b0, "reset");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b0, "idle");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b0, "idle");
    // Clean change
    add_change(10'h000, 10'h2A5, "clean");
    // Return to zero through reset
    add(10'h000, 1'b0, 10'h000, 1'b0, 1'b0, "rst2");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b0, "rst2_rel");
    // Two-cycle glitch is rejected
    add(10'h001, 1'b1, 10'h000, 1'b0, 1'b0, "glitch_sync");
    add(10'h001, 1'b1, 10'h000, 1'b0, 1'b0, "glitch_sync");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b1, "glitch_busy");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b1, "glitch_busy");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b0, "glitch_idle");
    add(10'h000, 1'b1, 10'h000, 1'b0, 1'b0, "glitch_idle");
    // Bounce 0x001 -> 0x003 restarts timing
    add(10'h001, 1'b1, 10'h000, 1'b0, 1'b0, "bounce_sync");
    add(10'h001, 1'b1, 10'h000, 1'b0, 1'b0, "bounce_sync");
    add(10'h001, 1'b1, 10'h000, 1'b0, 1'b1, "bounce_busy");
    for (int i = 0; i < 6; i++) add(10'h003, 1'b1, 10'h000, 1'b0, 1'b1, "bounce_busy");
    add(10'h003, 1'b1, 10'h003, 1'b1, 1'b0, "bounce_upd");
    add(10'h003, 1'b1, 10'h003, 1'b0, 1'b0, "bounce_hold");
    // Reset in the middle of a count
    add(10'h0F0, 1'b1, 10'h003, 1'b0, 1'b0, "midrst_sync");
    add(10'h0F0, 1'b1, 10'h003, 1'b0, 1'b0, "midrst_sync");
    add(10'h0F0, 1'b1, 10'h003, 1'b0, 1'b1, "midrst_busy");
    add(10'h0F0, 1'b1, 10'h003, 1'b0, 1'b1, "midrst_busy");
    add(10'h0F0, 1'b0, 10'h000, 1'b0, 1'b0, "midrst_rst");
    add_change(10'h000, 10'h0F0, "midrst_req");
    // Operand patterns for AluTop: add then sub
    add_change(10'h0F0, 10'h0D4, "alu_add");
    add_change(10'h0D4, 10'h0D5, "alu_sub");

    foreach (vecs[i]) begin
      string nm;
      step(vecs[i].raw, vecs[i].rst_n);
      nm = $sformatf("%s[%0d]", vecs[i].tag, i);
      check({nm, ".sw"},   io_sw,              vecs[i].sw);
      check({nm, ".chg"},  {9'b0, io_changed}, {9'b0, vecs[i].chg});
      check({nm, ".busy"}, {9'b0, io_busy},    {9'b0, vecs[i].busy});
    end

    // Single-cycle toggling against the stable value is never accepted
    pulses  = 0;
    sw_seen = io_sw;
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 0) ? 10'h3FF : 10'h0D5, 1'b1);
      if (io_changed) pulses++;
      if (io_sw !== 10'h0D5) sw_seen = io_sw;
    end
    check("toggle_pulses", W'(pulses), W'(0));
    check("toggle_sw", sw_seen, 10'h0D5);
    for (int i = 0; i < 4; i++) step(10'h0D5, 1'b1);
    check("toggle_settle_busy", {9'b0, io_busy}, 10'h000);

    // Latency of a held change, bounded wait
    @(negedge clk);
    io_sw_raw = 10'h3FF;
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (io_changed) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check("lat_found", {9'b0, found}, 10'h001);
    check("lat_cycles", W'(lat), W'(DC + 3));
    check("lat_sw", io_sw, 10'h3FF);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(10'h3FF, 1'b1);
      if (io_changed) pulses++;
    end
    check("lat_single_pulse", W'(pulses), W'(0));
    check("lat_sw_hold", io_sw, 10'h3FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
